// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO.
// Provides the count/pointer width function and the read-mode selectors.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 32;

  localparam int STANDARD = 0;
  localparam int FWFT     = 1;

  // Width of pointers and the occupancy count: one extra bit so that 0..FIFO_DEPTH fits.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_prog: synchronous write, registered read in
// standard mode, combinational read of the addressed word in first-word-fall-through mode.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int READ_MODE  = STANDARD
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic                                 we_i,
  input  logic [cnt_width(FIFO_DEPTH)-2:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0]                wdata_i,
  input  logic                                 re_i,
  input  logic [cnt_width(FIFO_DEPTH)-2:0]     raddr_i,
  output logic [DATA_WIDTH-1:0]                rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (READ_MODE == STANDARD) begin : g_std_read
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rdata_q <= '0;
      end else if (clear_i) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end else begin
        rdata_q <= rdata_q;
      end
    end

    assign rdata_o = rdata_q;
  end else begin : g_fwft_read
    logic unused_read;
    assign unused_read = re_i ^ clear_i ^ rst_i;
    assign rdata_o     = mem_q[raddr_i];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and selectable standard or first-word-fall-through reads.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              write_i,
  input  logic [DATA_WIDTH-1:0]             wr_data_i,
  input  logic                              read_i,
  output logic [DATA_WIDTH-1:0]             rd_data_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              almost_full_o,
  output logic                              almost_empty_o,
  output logic [cnt_width(FIFO_DEPTH)-1:0]  count_o,
  output logic                              overflow_o,
  output logic                              underflow_o
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < 4) ||
      (AF_LEVEL > FIFO_DEPTH) || (AE_LEVEL >= AF_LEVEL)) begin : g_bad_params
    $error("sync_fifo_prog: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // A full FIFO never writes through, even when the same cycle also reads.
  assign wr_accept = write_i && !full_q && !clear_i;
  assign rd_accept = read_i && !empty_q && !clear_i;

  // Next-state pointers, occupancy and sticky errors; flags decode from the next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q || (write_i && full_q);
      unf_d = unf_q || (read_i && empty_q);
    end
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .READ_MODE  (FWFT)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // In fall-through mode the head word is shown only while data is present.
  if (FWFT == STANDARD) begin : g_std_out
    assign rd_data_o = ram_rdata;
  end else begin : g_fwft_out
    assign rd_data_o = empty_q ? '0 : ram_rdata;
  end

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
